// File: rtl/conv_accum_3x3.sv
// conv_accum_3x3: accumulates nine signed product lanes over N_BEAT valid beats,
// then rounds, saturates and drains the nine Q6.10 results over valid/ready.
// Optional build macro CONV_ACCUM_RELU_EN: ReLU between rounding and saturation.
module conv_accum_3x3 #(
   parameter int N_BEAT     = 9,
   parameter int IN_W       = 32,
   parameter int ACC_W      = 36,
   parameter int FRAC_SHIFT = 10,
   parameter int OUT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  p1,
   input  logic [IN_W-1:0]  p2,
   input  logic [IN_W-1:0]  p3,
   input  logic [IN_W-1:0]  p4,
   input  logic [IN_W-1:0]  p5,
   input  logic [IN_W-1:0]  p6,
   input  logic [IN_W-1:0]  p7,
   input  logic [IN_W-1:0]  p8,
   input  logic [IN_W-1:0]  p9,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [3:0]       out_idx,
   output logic             done,
   output logic             sat_flag
);

   localparam int N_LANE = 9;
   localparam int CNT_W  = $clog2(N_BEAT + 1);

   localparam logic [ACC_W:0]        HALF_LSB = (ACC_W + 1)'(1) << (FRAC_SHIFT - 1);
   localparam logic signed [ACC_W:0] SAT_HI   = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W:0] SAT_LO   = ~SAT_HI;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         beat_q, beat_d;
   logic [3:0]               idx_q, idx_d;
   logic                     done_q, done_d;
   logic                     sat_q, sat_d;
   logic signed [ACC_W-1:0]  acc_q [0:N_LANE-1];
   logic signed [ACC_W-1:0]  acc_d [0:N_LANE-1];
   logic [IN_W-1:0]          p_s   [0:N_LANE-1];
   logic                     rs_sat_s;
   logic [OUT_W-1:0]         rs_data_s;

   // Returns {saturated, result}: round-half-up, optional ReLU, then clamp to OUT_W.
   function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_W-1:0] acc);
      logic [ACC_W:0]        biased;
      logic signed [ACC_W:0] r;
      logic                  sat;
      logic [OUT_W-1:0]      val;
      biased = {acc[ACC_W-1], acc} + HALF_LSB;
      r      = $signed(biased) >>> FRAC_SHIFT;
`ifdef CONV_ACCUM_RELU_EN
      if (r[ACC_W]) begin
         sat = 1'b0;
         val = {OUT_W{1'b0}};
      end else if (r > SAT_HI) begin
         sat = 1'b1;
         val = SAT_HI[OUT_W-1:0];
      end else begin
         sat = 1'b0;
         val = r[OUT_W-1:0];
      end
`else
      if (r > SAT_HI) begin
         sat = 1'b1;
         val = SAT_HI[OUT_W-1:0];
      end else if (r < SAT_LO) begin
         sat = 1'b1;
         val = SAT_LO[OUT_W-1:0];
      end else begin
         sat = 1'b0;
         val = r[OUT_W-1:0];
      end
`endif
      return {sat, val};
   endfunction

   assign p_s[0] = p1;
   assign p_s[1] = p2;
   assign p_s[2] = p3;
   assign p_s[3] = p4;
   assign p_s[4] = p5;
   assign p_s[5] = p6;
   assign p_s[6] = p7;
   assign p_s[7] = p8;
   assign p_s[8] = p9;

   // The output path is purely a function of the selected accumulator register.
   assign {rs_sat_s, rs_data_s} = round_sat(acc_q[idx_q]);

   assign out_data  = rs_data_s;
   assign out_idx   = idx_q;
   assign out_valid = (state_q == S_DRAIN);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign sat_flag  = sat_q;

   // Next-state logic for the window FSM, accumulators and drain index.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      idx_d   = idx_q;
      sat_d   = sat_q;
      done_d  = 1'b0;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCUM;
               beat_d  = {CNT_W{1'b0}};
               sat_d   = 1'b0;
               for (int k = 0; k < N_LANE; k++) begin
                  acc_d[k] = {ACC_W{1'b0}};
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               for (int k = 0; k < N_LANE; k++) begin
                  acc_d[k] = acc_q[k] + {{(ACC_W - IN_W){p_s[k][IN_W-1]}}, p_s[k]};
               end
               beat_d = beat_q + {{(CNT_W - 1){1'b0}}, 1'b1};
               if (beat_q == CNT_W'(N_BEAT - 1)) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_ACCUM;
               end
            end else begin
               state_d = S_ACCUM;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (rs_sat_s) begin
                  sat_d = 1'b1;
               end else begin
                  sat_d = sat_q;
               end
               if (idx_q == 4'd8) begin
                  state_d = S_IDLE;
                  idx_d   = 4'd0;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + 4'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= {CNT_W{1'b0}};
         idx_q   <= 4'd0;
         done_q  <= 1'b0;
         sat_q   <= 1'b0;
         for (int k = 0; k < N_LANE; k++) begin
            acc_q[k] <= {ACC_W{1'b0}};
         end
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         sat_q   <= sat_d;
         for (int k = 0; k < N_LANE; k++) begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

endmodule
